// File: rtl/if_stage_if.sv
// Fetch-stage bundle: IF/ID handshake, branch redirect bus and instruction SRAM port.
// The master side is the fetch stage; the slave side is the ID stage plus the SRAM.
interface if_stage_if;
    logic        id_allowin;
    logic [32:0] br_bus;
    logic        if_to_id_valid;
    logic [63:0] pc_inst_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  id_allowin,
        input  br_bus,
        input  inst_sram_rdata,
        output if_to_id_valid,
        output pc_inst_bus,
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output id_allowin,
        output br_bus,
        output inst_sram_rdata,
        input  if_to_id_valid,
        input  pc_inst_bus,
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, synchronous inst SRAM request, stall buffering
// of the fetched word and {pc,inst} hand-off to IF/ID with branch-redirect kill.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  fe_if
);

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] nextpc;
    logic        if_allowin;
    logic [31:0] inst;

    logic        if_valid_q,      if_valid_d;
    logic [31:0] if_pc_q,         if_pc_d;
    logic        br_pend_q,       br_pend_d;
    logic [31:0] br_pend_tgt_q,   br_pend_tgt_d;
    logic        rdata_fresh_q,   rdata_fresh_d;
    logic [31:0] inst_buf_q,      inst_buf_d;
    logic        buf_valid_q,     buf_valid_d;

    assign {br_taken, br_target} = fe_if.br_bus;

    always_comb begin
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pend_q) begin
            nextpc = br_pend_tgt_q;
        end else begin
            nextpc = if_pc_q + 32'd4;
        end
        if_allowin = !if_valid_q || fe_if.id_allowin;
    end

    always_comb begin
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        br_pend_d     = br_pend_q;
        br_pend_tgt_d = br_pend_tgt_q;
        rdata_fresh_d = rdata_fresh_q;
        inst_buf_d    = inst_buf_q;
        buf_valid_d   = buf_valid_q;

        if (if_allowin) begin
            if_valid_d    = 1'b1;
            if_pc_d       = nextpc;
            br_pend_d     = 1'b0;
            rdata_fresh_d = 1'b1;
            buf_valid_d   = 1'b0;
        end else begin
            // Stalled: if_valid_q is set and ID is refusing, so the SRAM word must be
            // captured on the one cycle it is presented.
            rdata_fresh_d = 1'b0;
            if (rdata_fresh_q) begin
                inst_buf_d  = fe_if.inst_sram_rdata;
                buf_valid_d = 1'b1;
            end
            if (br_taken) begin
                br_pend_d     = 1'b1;
                br_pend_tgt_d = br_target;
                if_valid_d    = 1'b0;
                buf_valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid_q    <= 1'b0;
            if_pc_q       <= RESET_PC - 32'd4;
            br_pend_q     <= 1'b0;
            br_pend_tgt_q <= 32'h0;
            rdata_fresh_q <= 1'b0;
            inst_buf_q    <= 32'h0;
            buf_valid_q   <= 1'b0;
        end else begin
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            br_pend_q     <= br_pend_d;
            br_pend_tgt_q <= br_pend_tgt_d;
            rdata_fresh_q <= rdata_fresh_d;
            inst_buf_q    <= inst_buf_d;
            buf_valid_q   <= buf_valid_d;
        end
    end

    // A redirect, taken now or still pending, means the IF-held instruction is on the wrong path.
    assign inst                  = buf_valid_q ? inst_buf_q : fe_if.inst_sram_rdata;
    assign fe_if.if_to_id_valid  = rst_n && if_valid_q && !br_taken && !br_pend_q;
    assign fe_if.pc_inst_bus     = {if_pc_q, inst};
    assign fe_if.inst_sram_en    = rst_n && if_allowin;
    assign fe_if.inst_sram_we    = 4'b0000;
    assign fe_if.inst_sram_addr  = nextpc;
    assign fe_if.inst_sram_wdata = 32'h0;

endmodule
